// File: rtl/fetch.sv
// fetch: RV32I instruction fetch stage for the rysyCore pipeline.
// Holds the PC and issues one word read at a time over req/gnt/rvalid. The
// result goes to decode as {inst, inst_pc, inst_valid}. A one-entry skid
// buffer catches a response that lands while decode is stalled.
// A redirect from execute always wins over everything else.
// Optional feature macro: FETCH_MISALIGN_EN. When it is defined, a misaligned
// redirect target raises misalign and parks fetch in HALT. When it is not
// defined, the low two target bits are cleared.
module fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_valid,
   output logic        misalign
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HALT} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] req_pc_q, req_pc_d;       // address of the outstanding request
   logic        kill_q, kill_d;           // outstanding response must be dropped
   logic        skid_valid_q, skid_valid_d;
   logic [31:0] skid_inst_q, skid_inst_d;
   logic [31:0] skid_pc_q, skid_pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] inst_pc_q, inst_pc_d;
   logic        inst_valid_q, inst_valid_d;
   logic        imem_req_q, imem_req_d;
`ifdef FETCH_MISALIGN_EN
   logic        misalign_q, misalign_d;
`endif

   logic        granted;
   logic        word_arrives;
   logic        word_to_out;
   logic        consume;
   logic        pending;
   logic [31:0] target_pc;

   assign granted      = imem_req_q && imem_gnt;
   assign word_arrives = (state_q == S_WAIT) && imem_rvalid && !kill_q;
   assign word_to_out  = word_arrives && (!inst_valid_q || !stall);
   assign consume      = inst_valid_q && !stall;
   // a response is still owed by memory after this edge unless it lands now
   assign pending      = ((state_q == S_WAIT) && !imem_rvalid) ||
                         ((state_q == S_REQ) && granted) ||
                         ((state_q == S_HALT) && kill_q && !imem_rvalid);
   assign target_pc    = redirect_pc & ~32'h3;

   // next-state: request sequencing, output/skid handshake, redirect override
   always_comb begin
      // NOTE: every _d starts from its _q so no path through this block infers a latch.
      state_d      = state_q;
      pc_d         = pc_q;
      req_pc_d     = req_pc_q;
      kill_d       = kill_q;
      skid_valid_d = skid_valid_q;
      skid_inst_d  = skid_inst_q;
      skid_pc_d    = skid_pc_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      inst_valid_d = inst_valid_q;
`ifdef FETCH_MISALIGN_EN
      misalign_d   = misalign_q;
`endif

      case (state_q)
         S_REQ: begin
            if (granted) begin
               state_d  = S_WAIT;
               pc_d     = pc_q + 32'd4;
               req_pc_d = pc_q;
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               state_d = S_REQ;
               if (kill_q) begin
                  kill_d = 1'b0;
               end else if (word_to_out) begin
                  inst_d       = imem_rdata;
                  inst_pc_d    = req_pc_q;
                  inst_valid_d = 1'b1;
               end else begin
                  skid_valid_d = 1'b1;
                  skid_inst_d  = imem_rdata;
                  skid_pc_d    = req_pc_q;
               end
            end
         end
         default: begin
            // HALT: a stale response drains silently
            if (imem_rvalid) kill_d = 1'b0;
         end
      endcase

      // decode took the current word and no fresh word replaced it
      if (consume && !word_to_out) begin
         if (skid_valid_q) begin
            inst_d       = skid_inst_q;
            inst_pc_d    = skid_pc_q;
            skid_valid_d = 1'b0;
         end else begin
            inst_d       = NOP_INST;
            inst_valid_d = 1'b0;
         end
      end

      if (redirect) begin
         pc_d         = target_pc;
         inst_d       = NOP_INST;
         inst_valid_d = 1'b0;
         skid_valid_d = 1'b0;
         kill_d       = pending;
         state_d      = pending ? S_WAIT : S_REQ;
`ifdef FETCH_MISALIGN_EN
         misalign_d   = |redirect_pc[1:0];
         if (|redirect_pc[1:0]) state_d = S_HALT;
`endif
      end

      imem_req_d = (state_d == S_REQ) && !skid_valid_d;
   end

   // state registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_REQ;
         pc_q         <= RESET_PC;
         req_pc_q     <= RESET_PC;
         kill_q       <= 1'b0;
         skid_valid_q <= 1'b0;
         skid_inst_q  <= NOP_INST;
         skid_pc_q    <= RESET_PC;
         inst_q       <= NOP_INST;
         inst_pc_q    <= RESET_PC;
         inst_valid_q <= 1'b0;
         imem_req_q   <= 1'b0;
`ifdef FETCH_MISALIGN_EN
         misalign_q   <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge value of the others.
         state_q      <= state_d;
         pc_q         <= pc_d;
         req_pc_q     <= req_pc_d;
         kill_q       <= kill_d;
         skid_valid_q <= skid_valid_d;
         skid_inst_q  <= skid_inst_d;
         skid_pc_q    <= skid_pc_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
         inst_valid_q <= inst_valid_d;
         imem_req_q   <= imem_req_d;
`ifdef FETCH_MISALIGN_EN
         misalign_q   <= misalign_d;
`endif
      end
   end

   assign imem_req   = imem_req_q;
   assign imem_addr  = pc_q;
   assign inst       = inst_q;
   assign inst_pc    = inst_pc_q;
   assign inst_valid = inst_valid_q;
`ifdef FETCH_MISALIGN_EN
   assign misalign   = misalign_q;
`else
   assign misalign   = 1'b0;
`endif

endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed bench for the fetch stage. The instruction memory model
// grants in the same cycle and answers one cycle later, or two cycles later
// when lat2 is set.
module tb_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_valid;
   logic        misalign;

   int checks = 0;
   int failures = 0;

   logic        lat2 = 1'b0;
   logic        rv_force = 1'b0;
   logic [31:0] force_data = 32'hDEAD_BEEF;
   logic        rv1 = 1'b0, rv2 = 1'b0;
   logic [31:0] d1 = 32'h0, d2 = 32'h0;

   fetch dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .inst        (inst),
      .inst_pc     (inst_pc),
      .inst_valid  (inst_valid),
      .misalign    (misalign)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0:   return 32'h0002_30B7;
         32'h4:   return 32'h0540_8113;
         32'h8:   return 32'h0011_01B3;
         32'hC:   return 32'h4011_0233;
         default: return a ^ 32'h5A5A_0000;
      endcase
   endfunction

   assign imem_gnt    = imem_req;
   assign imem_rvalid = (lat2 ? rv2 : rv1) | rv_force;
   assign imem_rdata  = rv_force ? force_data : (lat2 ? d2 : d1);

   always @(posedge clk) begin
      rv1 <= imem_req && imem_gnt;
      d1  <= mem_word(imem_addr);
      rv2 <= rv1;
      d2  <= d1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // advance until a word is shown, with a bounded budget
   task automatic wait_valid(input string tag);
      int n = 0;
      while (!inst_valid && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_timeout"}, {31'd0, inst_valid}, 32'd1);
   endtask

   task automatic expect_word(input string tag, input logic [31:0] pc);
      wait_valid(tag);
      check({tag, "_pc"}, inst_pc, pc);
      check({tag, "_inst"}, inst, mem_word(pc));
   endtask

   task automatic setup_at_pc4();
      do_reset();
      expect_word("setup0", 32'h0);
      tick();
      expect_word("setup4", 32'h4);
   endtask

   initial begin
      // reset values
      tick();
      check("rst_req", {31'd0, imem_req}, 32'd0);
      check("rst_addr", imem_addr, 32'h0);
      check("rst_inst", inst, NOP);
      check("rst_inst_pc", inst_pc, 32'h0);
      check("rst_valid", {31'd0, inst_valid}, 32'd0);
      check("rst_misalign", {31'd0, misalign}, 32'd0);

      // 1: first request one cycle after release, four words in order
      rst = 1'b0;
      check("t1_req_low", {31'd0, imem_req}, 32'd0);
      tick();
      check("t1_req_high", {31'd0, imem_req}, 32'd1);
      check("t1_addr0", imem_addr, 32'h0);
      for (int i = 0; i < 4; i++) begin
         expect_word($sformatf("t1_w%0d", i), 32'(i * 4));
         tick();
         check($sformatf("t1_pulse%0d", i), {31'd0, inst_valid}, 32'd0);
      end

      // 2: stall holds 0x4 while 0x8 lands in the skid
      setup_at_pc4();
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("t2_hold_pc%0d", i), inst_pc, 32'h4);
         check($sformatf("t2_hold_v%0d", i), {31'd0, inst_valid}, 32'd1);
         if (i >= 1) check($sformatf("t2_noreq%0d", i), {31'd0, imem_req}, 32'd0);
      end
      check("t2_hold_inst", inst, 32'h0540_8113);
      stall = 1'b0;
      tick();
      check("t2_skid_pc", inst_pc, 32'h8);
      check("t2_skid_inst", inst, 32'h0011_01B3);
      check("t2_skid_v", {31'd0, inst_valid}, 32'd1);
      check("t2_req_again", {31'd0, imem_req}, 32'd1);
      check("t2_addr_c", imem_addr, 32'hC);

      // 3: redirect in WAIT while the 0x8 response lands
      setup_at_pc4();
      tick();
      redirect = 1'b1;
      redirect_pc = 32'h100;
      tick();
      redirect = 1'b0;
      check("t3_valid0", {31'd0, inst_valid}, 32'd0);
      check("t3_req", {31'd0, imem_req}, 32'd1);
      check("t3_addr", imem_addr, 32'h100);
      expect_word("t3_new", 32'h100);

      // 3b: redirect in WAIT before the response (slow memory) -> kill
      lat2 = 1'b1;
      setup_at_pc4();
      tick();
      redirect = 1'b1;
      redirect_pc = 32'h200;
      tick();
      redirect = 1'b0;
      check("t3b_req_wait", {31'd0, imem_req}, 32'd0);
      check("t3b_valid0", {31'd0, inst_valid}, 32'd0);
      check("t3b_addr", imem_addr, 32'h200);
      expect_word("t3b_new", 32'h200);
      lat2 = 1'b0;

      // 4: redirect with stall and full skid
      setup_at_pc4();
      stall = 1'b1;
      tick();
      tick();
      tick();
      redirect = 1'b1;
      redirect_pc = 32'h300;
      tick();
      redirect = 1'b0;
      check("t4_valid0", {31'd0, inst_valid}, 32'd0);
      check("t4_req", {31'd0, imem_req}, 32'd1);
      check("t4_addr", imem_addr, 32'h300);
      stall = 1'b0;
      expect_word("t4_new", 32'h300);

      // 5: reset pulsed in WAIT, stray rvalid right after release
      do_reset();
      tick();
      tick();
      rst = 1'b1;
      #1;
      check("t5_async_req", {31'd0, imem_req}, 32'd0);
      tick();
      rst = 1'b0;
      rv_force = 1'b1;
      tick();
      rv_force = 1'b0;
      check("t5_ignored", {31'd0, inst_valid}, 32'd0);
      check("t5_req", {31'd0, imem_req}, 32'd1);
      check("t5_addr", imem_addr, 32'h0);
      expect_word("t5_restart", 32'h0);

      // wrap: redirect on a granted REQ to the top word, then wrap to 0
      do_reset();
      tick();
      redirect = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect = 1'b0;
      expect_word("wrap_top", 32'hFFFF_FFFC);
      tick();
      expect_word("wrap_zero", 32'h0);

      // 6: misaligned redirect target
      do_reset();
      tick();
      tick();
      redirect = 1'b1;
      redirect_pc = 32'h102;
      tick();
      redirect = 1'b0;
`ifdef FETCH_MISALIGN_EN
      check("t6_misalign", {31'd0, misalign}, 32'd1);
      tick();
      tick();
      check("t6_halt_req", {31'd0, imem_req}, 32'd0);
      check("t6_halt_valid", {31'd0, inst_valid}, 32'd0);
      redirect = 1'b1;
      redirect_pc = 32'h200;
      tick();
      redirect = 1'b0;
      check("t6_clear", {31'd0, misalign}, 32'd0);
      expect_word("t6_resume", 32'h200);
`else
      check("t6_misalign_off", {31'd0, misalign}, 32'd0);
      expect_word("t6_aligned", 32'h100);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
